// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over XLEN cycles, with early completion for divide special cases.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] y_q, y_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  // Operand decode at accept time
  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_y;

  always_comb begin
    a_signed  = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_signed  = op[2] ? ~op[0] : ~op[1];
    sa        = a_signed & a[XLEN-1];
    sb        = b_signed & b[XLEN-1];
    abs_a     = sa ? (~a + XLEN'(1)) : a;
    abs_b     = sb ? (~b + XLEN'(1)) : b;
    div_zero  = op[2] && (b == '0);
    div_ovf   = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special_y = '0;
    if (div_zero)     special_y = op[1] ? a : '1;
    else if (div_ovf) special_y = op[1] ? '0 : a;
  end

  // One iteration of the shift-add multiply or restoring divide
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_raw, final_y;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_diff[XLEN];
    if (op_q[2]) begin
      step_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ok};
    end else if (lo_q[0]) begin
      {step_hi, step_lo} = {mul_sum, lo_q[XLEN-1:1]};
    end else begin
      {step_hi, step_lo} = {1'b0, hi_q, lo_q[XLEN-1:1]};
    end
    prod    = {step_hi, step_lo};
    prod_s  = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
    div_raw = op_q[1] ? step_hi : step_lo;
    if (op_q[2])
      final_y = neg_q ? (~div_raw + XLEN'(1)) : div_raw;
    else if (op_q[1:0] == 2'b00)
      final_y = prod_s[XLEN-1:0];
    else
      final_y = prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q && !flush) begin
          op_d       = op;
          cnt_d      = '0;
          neg_d      = (op[2] && op[1]) ? sa : (sa ^ sb);
          in_ready_d = 1'b0;
          if (div_zero || div_ovf) begin
            y_d         = special_y;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            hi_d    = '0;
            lo_d    = op[2] ? abs_a : abs_b;
            opnd_d  = op[2] ? abs_b : abs_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == CW'(XLEN-1)) begin
          y_d         = final_y;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
    // A pipeline redirect abandons whatever is in flight, including an unclaimed result
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule
